// File: rtl/vga_ctrl_if.sv
// Pixel-side bundle of the VGA timing controller: the request to the picture
// stage, the pixel coming back from it, and the signals driven to the DAC.
interface vga_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        rgb_valid;
  logic        frame_start;

  modport master (
    input  pix_data,
    output pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start
  );
endinterface

// File: rtl/vga_ctrl.sv
// VGA raster timing: free-running line/frame counters with all sync, request
// and valid windows decoded from the registered counters.
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  vga_ctrl_if.master  vga
);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
  localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK + H_LEFT - 1);
  localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK + V_TOP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);

  // Catch inconsistent overrides at elaboration rather than as a skewed raster.
  if (H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT != H_TOTAL) begin : g_h_total_check
    $error("vga_ctrl: horizontal segments do not sum to H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT != V_TOTAL) begin : g_v_total_check
    $error("vga_ctrl: vertical segments do not sum to V_TOTAL");
  end

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;

  // NOTE: counters use non-blocking assignments and an asynchronous clear so a
  // mid-frame reset restarts timing immediately, without waiting for a clock.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  logic h_req;
  logic h_act;
  logic v_act;
  logic req;

  assign h_req = (cnt_h >= H_REQ_START) && (cnt_h < H_REQ_END);
  assign h_act = (cnt_h >= H_ACT_START) && (cnt_h < H_ACT_END);
  assign v_act = (cnt_v >= V_ACT_START) && (cnt_v < V_ACT_END);
  assign req   = h_req && v_act;

  // NOTE: every timing output is a pure decode of the two counters; only rgb
  // looks at pix_data, so sync and request timing never depend on the picture.
  assign vga.hsync       = (cnt_h <= H_SYNC_LAST);
  assign vga.vsync       = (cnt_v <= V_SYNC_LAST);
  assign vga.rgb_valid   = h_act && v_act;
  assign vga.frame_start = (cnt_h == '0) && (cnt_v == '0);
  assign vga.pix_x       = req ? (cnt_h - H_REQ_START) : 10'h3FF;
  assign vga.pix_y       = req ? (cnt_v - V_ACT_START) : 10'h3FF;
  assign vga.rgb         = vga.rgb_valid ? vga.pix_data : 16'h0000;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a default-size instance and a shrunken-raster instance
// run side by side against a position model and a pixel scoreboard.
module tb_vga_ctrl;

  localparam int A_HS = 96, A_HB = 40, A_HL = 8, A_HV = 640, A_HR = 8, A_HF = 8, A_HT = 800;
  localparam int A_VS = 2,  A_VB = 25, A_VP = 8, A_VV = 480, A_VO = 8, A_VF = 2, A_VT = 525;
  localparam int B_HS = 8,  B_HB = 4,  B_HL = 2, B_HV = 32,  B_HR = 2, B_HF = 2, B_HT = 50;
  localparam int B_VS = 2,  B_VB = 3,  B_VP = 1, B_VV = 6,   B_VO = 1, B_VF = 1, B_VT = 14;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_ctrl_if bus_a ();
  vga_ctrl_if bus_b ();

  vga_ctrl dut_a (
    .vga_clk   (clk),
    .sys_rst_n (rst_a),
    .vga       (bus_a.master)
  );

  vga_ctrl #(
    .H_SYNC (B_HS), .H_BACK (B_HB), .H_LEFT (B_HL), .H_VALID (B_HV),
    .H_RIGHT(B_HR), .H_FRONT(B_HF), .H_TOTAL(B_HT),
    .V_SYNC (B_VS), .V_BACK (B_VB), .V_TOP  (B_VP), .V_VALID (B_VV),
    .V_BOTTOM(B_VO), .V_FRONT(B_VF), .V_TOTAL(B_VT)
  ) dut_b (
    .vga_clk   (clk),
    .sys_rst_n (rst_b),
    .vga       (bus_b.master)
  );

  typedef struct {
    logic       hs, vs, valid, fs, req;
    logic [9:0] px, py;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          ta = 0;
  int          tb_t = 0;
  bit          run_a = 1'b0;
  bit          run_b = 1'b0;
  logic [15:0] pend_a = 16'h0000;
  logic [15:0] pend_b = 16'h0000;
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

  // Raster position recomputed from elapsed cycles since reset release.
  function automatic exp_t model(input int t, input int hs, input int hst, input int hv,
                                 input int ht, input int vs, input int vst, input int vv,
                                 input int vt);
    exp_t m;
    int   h, v;
    logic hreq, hact, vact;
    h    = t % ht;
    v    = (t / ht) % vt;
    hreq = (h >= hst - 1) && (h < hst - 1 + hv);
    hact = (h >= hst) && (h < hst + hv);
    vact = (v >= vst) && (v < vst + vv);
    m.hs    = (h < hs);
    m.vs    = (v < vs);
    m.valid = hact && vact;
    m.req   = hreq && vact;
    m.fs    = (h == 0) && (v == 0);
    m.px    = m.req ? 10'(h - hst + 1) : 10'h3FF;
    m.py    = m.req ? 10'(v - vst) : 10'h3FF;
    return m;
  endfunction

  task automatic check_dut(input int id, input int t, input logic hs, input logic vs,
                           input logic valid, input logic fs, input logic [9:0] px,
                           input logic [9:0] py, input logic [15:0] rgb);
    exp_t        e;
    logic [23:0] obs, exp_v;
    logic [15:0] exp_rgb;
    if (id == 0)
      e = model(t, A_HS, A_HS + A_HB + A_HL, A_HV, A_HT, A_VS, A_VS + A_VB + A_VP, A_VV, A_VT);
    else
      e = model(t, B_HS, B_HS + B_HB + B_HL, B_HV, B_HT, B_VS, B_VS + B_VB + B_VP, B_VV, B_VT);
    obs   = {hs, vs, valid, fs, px, py};
    exp_v = {e.hs, e.vs, e.valid, e.fs, e.px, e.py};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL timing_%0d t=%0d observed=%h expected=%h", id, t, obs, exp_v);
    end
    exp_rgb = 16'h0000;
    if (e.valid) begin
      if (id == 0 && q_a.size() > 0) exp_rgb = q_a.pop_front();
      if (id == 1 && q_b.size() > 0) exp_rgb = q_b.pop_front();
    end
    checks++;
    assert (rgb === exp_rgb) else begin
      errors++;
      $error("FAIL rgb_%0d t=%0d observed=%h expected=%h", id, t, rgb, exp_rgb);
    end
    if (e.req) begin
      if (id == 0) q_a.push_back({6'b0, e.px});
      else         q_b.push_back({6'b0, e.px});
    end
  endtask

  task automatic check_reset(input int id, input logic hs, input logic vs, input logic valid,
                             input logic fs, input logic [9:0] px, input logic [9:0] py,
                             input logic [15:0] rgb);
    logic [39:0] obs;
    obs = {hs, vs, valid, fs, px, py, rgb};
    checks++;
    assert (obs === {1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h0000}) else begin
      errors++;
      $error("FAIL reset_%0d observed=%h expected=%h", id, obs,
             {1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    end
  endtask

  // One pixel clock: the picture stage registers the previous request, then
  // both instances are compared against the model.
  task automatic step();
    @(posedge clk);
    if (run_a) ta++;
    if (run_b) tb_t++;
    #1;
    bus_a.pix_data = pend_a;
    bus_b.pix_data = pend_b;
    #1;
    check_dut(0, ta, bus_a.hsync, bus_a.vsync, bus_a.rgb_valid, bus_a.frame_start,
              bus_a.pix_x, bus_a.pix_y, bus_a.rgb);
    check_dut(1, tb_t, bus_b.hsync, bus_b.vsync, bus_b.rgb_valid, bus_b.frame_start,
              bus_b.pix_x, bus_b.pix_y, bus_b.rgb);
    pend_a = {6'b0, bus_a.pix_x};
    pend_b = {6'b0, bus_b.pix_x};
  endtask

  initial begin
    int n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.pix_data = 16'h0000;
    bus_b.pix_data = 16'h0000;

    #12;
    check_reset(0, bus_a.hsync, bus_a.vsync, bus_a.rgb_valid, bus_a.frame_start,
                bus_a.pix_x, bus_a.pix_y, bus_a.rgb);
    check_reset(1, bus_b.hsync, bus_b.vsync, bus_b.rgb_valid, bus_b.frame_start,
                bus_b.pix_x, bus_b.pix_y, bus_b.rgb);

    // Release between edges; the first rising edge moves both rasters to t=1.
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    run_a = 1'b1;
    run_b = 1'b1;

    // Default raster through line 36: blanking lines, first active line 35.
    repeat (28900) step();

    // Park the small raster inside its active area, then reset it mid-frame.
    for (int i = 0; i < 700; i++) begin
      if ((tb_t % B_HT) == 30 && ((tb_t / B_HT) % B_VT) == 8) break;
      step();
    end
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    run_b = 1'b0;
    tb_t  = 0;
    q_b.delete();
    #1;
    check_reset(1, bus_b.hsync, bus_b.vsync, bus_b.rgb_valid, bus_b.frame_start,
                bus_b.pix_x, bus_b.pix_y, bus_b.rgb);
    repeat (3) step();
    #2;
    rst_b = 1'b1;
    run_b = 1'b1;

    // Next frame_start must arrive exactly one frame after release.
    n = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      n++;
      if (bus_b.frame_start) break;
    end
    checks++;
    assert (n === B_HT * B_VT) else begin
      errors++;
      $error("FAIL frame_period observed=%0d expected=%0d", n, B_HT * B_VT);
    end

    // A further full small frame to cover the bottom border and wrap.
    repeat (B_HT * B_VT + 60) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameters (name, default, meaning): H_SYNC 96 hsync width; H_BACK 40 back porch; H_LEFT 8 left border; H_VALID 640 active width; H_RIGHT 8 right border; H_FRONT 8 front porch; H_TOTAL 800 line length.
REQ-002 Parameters (name, default, meaning): V_SYNC 2; V_BACK 25; V_TOP 8; V_VALID 480; V_BOTTOM 8; V_FRONT 2; V_TOTAL 525, all in lines.
REQ-003 vga_clk  input  1  pixel clock, 25.175 MHz nominal; all state on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pix_data  input  16  RGB565 pixel from downstream picture stage; registered there, so valid one cycle after pix_x/pix_y.
REQ-006 pix_x  output  10  requested pixel column 0..639; 10'h3FF when no request.
REQ-007 pix_y  output  10  requested pixel row 0..479; 10'h3FF when no request.
REQ-008 hsync  output  1  horizontal sync, high during sync pulse.
REQ-009 vsync  output  1  vertical sync, high during sync pulse.
REQ-010 rgb  output  16  pixel to DAC; 16'h0000 outside active area.
REQ-011 rgb_valid  output  1  high while rgb carries active-area pixel.
REQ-012 frame_start  output  1  one-cycle pulse at first clock of each frame.

Function
REQ-013 cnt_h (10 bit) SHALL count 0..H_TOTAL-1, wrapping to 0 after 799.
REQ-014 cnt_v (10 bit) SHALL increment only when cnt_h==799; wrap to 0 when cnt_v==524 and cnt_h==799; otherwise hold.
REQ-015 hsync SHALL be 1 iff cnt_h <= H_SYNC-1 (0..95).
REQ-016 vsync SHALL be 1 iff cnt_v <= V_SYNC-1 (0..1).
REQ-017 rgb_valid SHALL be 1 iff cnt_h in [144,784) and cnt_v in [35,515) (start = SYNC+BACK+LEFT per axis).
REQ-018 Request window SHALL lead rgb_valid by exactly one cycle horizontally: cnt_h in [143,783), same cnt_v window.
REQ-019 Inside request window pix_x SHALL equal cnt_h-143 and pix_y SHALL equal cnt_v-35; outside, both 10'h3FF.
REQ-020 rgb SHALL equal pix_data when rgb_valid, else 16'h0000; pixel requested at pix_x=N SHALL appear on rgb in the cycle rgb_valid covers column N.
REQ-021 frame_start SHALL be 1 iff cnt_h==0 and cnt_v==0.
REQ-022 hsync, vsync, rgb_valid, pix_x, pix_y, frame_start SHALL be glitch-free decodes of registered counters only; no dependency on pix_data.
REQ-023 Frame period SHALL be exactly H_TOTAL*V_TOTAL = 420000 cycles; line period exactly 800 cycles.
REQ-024 Parameter overrides SHALL re-derive all windows; no hard-coded 143/144/35 constants in logic.

Reset
REQ-025 sys_rst_n low SHALL immediately clear cnt_h and cnt_v to 0, independent of vga_clk.
REQ-026 During reset outputs SHALL read: hsync=1, vsync=1, rgb_valid=0, rgb=16'h0000, pix_x=pix_y=10'h3FF, frame_start=1.
REQ-027 On release counting SHALL start at first rising edge; reset asserted mid-frame SHALL restart timing from cnt_h=cnt_v=0 with no partial-line residue.

Verification
REQ-028 Release reset, run 420000 cycles -> frame_start pulses at cycle 0 and 420000 only; hsync high 96 of every 800 cycles; vsync high for 1600 cycles per frame.
REQ-029 Line 35 (first active): pix_x goes 0 at cnt_h=143, 639 at cnt_h=782, 3FF at cnt_h=783; rgb_valid high cnt_h 144..783.
REQ-030 Drive pix_data = {6'b0,pix_x} registered one cycle -> rgb equals column index 0..639 across each active line, 16'h0000 in borders.
REQ-031 Lines 0..34 and 515..524 -> pix_y=3FF, rgb_valid=0 for all cnt_h; line 514 -> pix_y=479.
REQ-032 Assert sys_rst_n low at cnt_h=400, cnt_v=200, asynchronously between edges -> outputs take reset values before next edge; after release, next frame_start exactly 420000 cycles later.
REQ-033 Override H_VALID=320, V_VALID=240 (totals adjusted) -> pix_x max 319, pix_y max 239, windows shift consistently.
